// File: rtl/frame_stream_source_pkg.sv
// Shared frame geometry, sample/coordinate types and addressing helpers
// for the frame-buffered raster pixel source.
package frame_stream_source_pkg;

  localparam int unsigned FRAME_COLS = 24;
  localparam int unsigned FRAME_ROWS = 32;
  localparam int unsigned PIX_W      = 21;
  localparam int unsigned COORD_W    = 5;
  localparam int unsigned OFF_W      = 10;
  localparam int unsigned ADDR_W     = OFF_W + 1;

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef logic [COORD_W-1:0]      coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_BLANK,
    ST_DRAIN
  } state_e;

  // Bank bit sits above the in-frame offset v*COLS+h.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic bank, input coord_t h,
                                                 input coord_t v);
    logic [OFF_W-1:0] off;
    off = OFF_W'(v) * OFF_W'(FRAME_COLS) + OFF_W'(h);
    return {bank, off};
  endfunction

  function automatic logic in_frame(input coord_t h, input coord_t v);
    return (32'(h) < FRAME_COLS) && (32'(v) < FRAME_ROWS);
  endfunction

endpackage

// File: rtl/frame_stream_source_if.sv
// Write-side and stream-side signals of frame_stream_source; slave is the
// source block, master is whoever feeds the frame and consumes the stream.
interface frame_stream_source_if;
  import frame_stream_source_pkg::*;

  coord_t wr_hcount_in;
  coord_t wr_vcount_in;
  pixel_t wr_data_in;
  logic   wr_valid_in;
  logic   wr_frame_done_in;
  logic   start_in;

  logic   frame_avail_out;
  logic   busy_out;
  pixel_t pixel_data_out;
  coord_t hcount_out;
  coord_t vcount_out;
  logic   data_valid_out;
  logic   done_out;

  modport master (
    output wr_hcount_in, wr_vcount_in, wr_data_in, wr_valid_in, wr_frame_done_in, start_in,
    input  frame_avail_out, busy_out, pixel_data_out, hcount_out, vcount_out,
           data_valid_out, done_out
  );

  modport slave (
    input  wr_hcount_in, wr_vcount_in, wr_data_in, wr_valid_in, wr_frame_done_in, start_in,
    output frame_avail_out, busy_out, pixel_data_out, hcount_out, vcount_out,
           data_valid_out, done_out
  );

endinterface

// File: rtl/frame_stream_source_ram.sv
// True dual-port, read-first, single-clock block RAM with registered outputs
// (two-cycle read latency when regce is held high).
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int unsigned RAM_WIDTH = 18,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned AW        = $clog2(RAM_DEPTH)
) (
  input  logic [AW-1:0]        addra,
  input  logic [AW-1:0]        addrb,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic [RAM_WIDTH-1:0] dinb,
  input  logic                 clka,
  input  logic                 wea,
  input  logic                 web,
  input  logic                 ena,
  input  logic                 enb,
  input  logic                 rsta,
  input  logic                 rstb,
  input  logic                 regcea,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] douta,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;
  logic [RAM_WIDTH-1:0] ram_data_b;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_a <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dinb;
      ram_data_b <= mem[addrb];
    end
  end

  always_ff @(posedge clka) begin
    if (rsta)        douta <= '0;
    else if (regcea) douta <= ram_data_a;
  end

  always_ff @(posedge clka) begin
    if (rstb)        doutb <= '0;
    else if (regceb) doutb <= ram_data_b;
  end

endmodule

// File: rtl/frame_stream_source.sv
// Double-buffered frame store replayed in raster order with horizontal
// blanking; hcount/vcount hold through blanking so row starts are 23->0 edges.
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int unsigned H_BLANK = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  frame_stream_source_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  state_e          state_q, state_d;
  coord_t          h_q, h_d;
  coord_t          v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic            avail_q, avail_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rd_en;

  logic            vld1_q, vld2_q;
  coord_t          hc1_q, vc1_q, hc2_q, vc2_q;

  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              wr_en;
  logic [PIX_W-1:0]  ram_rd_data;
  logic [PIX_W-1:0]  unused_doutb;

  assign wr_en   = bus.wr_valid_in && in_frame(bus.wr_hcount_in, bus.wr_vcount_in);
  assign wr_addr = pix_addr(~rd_bank_q, bus.wr_hcount_in, bus.wr_vcount_in);
  assign rd_addr = pix_addr(rd_bank_q, h_q, v_q);

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH (PIX_W),
    .RAM_DEPTH (2 ** ADDR_W)
  ) u_ram (
    .addra  (rd_addr),
    .addrb  (wr_addr),
    .dina   ('0),
    .dinb   (bus.wr_data_in),
    .clka   (clk_in),
    .wea    (1'b0),
    .web    (wr_en),
    .ena    (1'b1),
    .enb    (1'b1),
    .rsta   (1'b0),
    .rstb   (1'b0),
    .regcea (1'b1),
    .regceb (1'b0),
    .douta  (ram_rd_data),
    .doutb  (unused_doutb)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    avail_d   = avail_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en     = 1'b0;

    if (state_q != ST_IDLE && bus.wr_frame_done_in) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // A deferred swap wins this cycle; a concurrent frame-done is absorbed.
        if (pend_q) begin
          rd_bank_d = ~rd_bank_q;
          avail_d   = 1'b1;
          pend_d    = 1'b0;
        end else if (bus.start_in && avail_q) begin
          state_d = ST_ROW;
          h_d     = '0;
          v_d     = '0;
          avail_d = 1'b0;
          busy_d  = 1'b1;
          if (bus.wr_frame_done_in) pend_d = 1'b1;
        end else if (bus.wr_frame_done_in) begin
          rd_bank_d = ~rd_bank_q;
          avail_d   = 1'b1;
        end
      end
      ST_ROW: begin
        rd_en = 1'b1;
        if (h_q == coord_t'(FRAME_COLS - 1)) begin
          state_d = ST_BLANK;
          h_d     = '0;
          cnt_d   = '0;
        end else begin
          h_d = h_q + coord_t'(1);
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (v_q == coord_t'(FRAME_ROWS - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            v_d     = v_q + coord_t'(1);
            state_d = ST_ROW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
      rd_bank_q <= 1'b0;
      avail_q   <= 1'b0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      rd_bank_q <= rd_bank_d;
      avail_q   <= avail_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Coordinates track the two-cycle RAM latency; the output stage only
  // loads on valid so blanking keeps the last pixel's position.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      hc1_q  <= '0;
      vc1_q  <= '0;
      hc2_q  <= '0;
      vc2_q  <= '0;
    end else begin
      vld1_q <= rd_en;
      hc1_q  <= h_q;
      vc1_q  <= v_q;
      vld2_q <= vld1_q;
      if (vld1_q) begin
        hc2_q <= hc1_q;
        vc2_q <= vc1_q;
      end
    end
  end

  assign bus.frame_avail_out = avail_q;
  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.data_valid_out  = vld2_q;
  assign bus.hcount_out      = hc2_q;
  assign bus.vcount_out      = vc2_q;
  assign bus.pixel_data_out  = vld2_q ? pixel_t'(ram_rd_data) : '0;

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source: replay, ping-pong, event collisions,
// out-of-range writes, mid-frame reset and row-boundary detection.
module tb_frame_stream_source;
  import frame_stream_source_pkg::*;

  localparam int PERIOD    = 28;                 // COLS + H_BLANK
  localparam int FRAME_CYC = 1 + 32 * PERIOD + 2; // start cycle to done cycle

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  frame_stream_source_if bus();

  frame_stream_source #(.H_BLANK(4)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Row-boundary detector as a rolling line buffer sees it.
  bit lb_en = 1'b0;
  int lb_rows = 0;
  int lb_prev_h = 0;
  always @(negedge clk) begin
    if (bus.data_valid_out) begin
      if (lb_en && bus.hcount_out == 0 && lb_prev_h != 0) begin
        check_val("lb_row_v", int'(bus.vcount_out), lb_rows % 32);
        check_val("lb_row_pix", int'(bus.pixel_data_out), (lb_rows % 32) * 100);
        lb_rows++;
      end
      lb_prev_h = int'(bus.hcount_out);
    end
  end

  task automatic write_frame(input int mode);
    for (int v = 0; v < 32; v++) begin
      for (int h = 0; h < 24; h++) begin
        @(posedge clk); #1;
        bus.wr_valid_in  = 1'b1;
        bus.wr_hcount_in = coord_t'(h);
        bus.wr_vcount_in = coord_t'(v);
        bus.wr_data_in   = (mode == 0) ? pixel_t'(v * 100 + h) : pixel_t'(-h);
      end
    end
    @(posedge clk); #1;
    bus.wr_valid_in = 1'b0;
  endtask

  task automatic write_oor();
    int vs[3];
    vs = '{0, 5, 30};
    for (int i = 0; i < 3; i++) begin
      for (int h = 24; h < 32; h++) begin
        @(posedge clk); #1;
        bus.wr_valid_in  = 1'b1;
        bus.wr_hcount_in = coord_t'(h);
        bus.wr_vcount_in = coord_t'(vs[i]);
        bus.wr_data_in   = pixel_t'(777);
      end
    end
    @(posedge clk); #1;
    bus.wr_valid_in = 1'b0;
  endtask

  task automatic pulse_frame_done();
    @(posedge clk); #1; bus.wr_frame_done_in = 1'b1;
    @(posedge clk); #1; bus.wr_frame_done_in = 1'b0;
  endtask

  // mode 0: v*100+h ramp, mode 1: -h
  task automatic stream(input int mode, input bit with_done, input bit exp_avail);
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    if (with_done) bus.wr_frame_done_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    if (with_done) bus.wr_frame_done_in = 1'b0;
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
      int t, row, col, exp_pix;
      bit ev;
      @(negedge clk);
      t   = k - 3;
      row = (t >= 0) ? t / PERIOD : 0;
      col = (t >= 0) ? t % PERIOD : 0;
      ev  = (t >= 0) && (row < 32) && (col < 24);
      exp_pix = (mode == 0) ? row * 100 + col : -col;
      check_val("valid", int'(bus.data_valid_out), int'(ev));
      check_val("done", int'(bus.done_out), int'(k == FRAME_CYC));
      check_val("busy", int'(bus.busy_out), int'(k < FRAME_CYC));
      if (ev) begin
        check_val("pix", int'(bus.pixel_data_out), exp_pix);
        check_val("hcnt", int'(bus.hcount_out), col);
        check_val("vcnt", int'(bus.vcount_out), row);
      end else if (t >= 0) begin
        check_val("hhold", int'(bus.hcount_out), 23);
        check_val("vhold", int'(bus.vcount_out), (row < 32) ? row : 31);
      end
      if (k == 100) check_val("avail_mid", int'(bus.frame_avail_out), 0);
      if (k == FRAME_CYC + 1) check_val("avail_after", int'(bus.frame_avail_out), int'(exp_avail));
    end
  endtask

  task automatic expect_idle(input string tag, input int n, input bit exp_avail);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val({tag, "_busy"}, int'(bus.busy_out), 0);
      check_val({tag, "_valid"}, int'(bus.data_valid_out), 0);
    end
    check_val({tag, "_avail"}, int'(bus.frame_avail_out), int'(exp_avail));
  endtask

  initial begin
    bus.wr_hcount_in     = '0;
    bus.wr_vcount_in     = '0;
    bus.wr_data_in       = '0;
    bus.wr_valid_in      = 1'b0;
    bus.wr_frame_done_in = 1'b0;
    bus.start_in         = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_avail", int'(bus.frame_avail_out), 0);
    check_val("rst_busy", int'(bus.busy_out), 0);
    check_val("rst_valid", int'(bus.data_valid_out), 0);
    check_val("rst_done", int'(bus.done_out), 0);
    check_val("rst_pix", int'(bus.pixel_data_out), 0);
    check_val("rst_h", int'(bus.hcount_out), 0);
    check_val("rst_v", int'(bus.vcount_out), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // start without a frame is ignored
    @(posedge clk); #1; bus.start_in = 1'b1;
    @(posedge clk); #1; bus.start_in = 1'b0;
    expect_idle("nostart", 5, 1'b0);

    // ramp into bank 1 plus aliasing out-of-range writes, then replay
    write_frame(0);
    write_oor();
    pulse_frame_done();
    @(negedge clk);
    check_val("avail_first", int'(bus.frame_avail_out), 1);
    stream(0, 1'b0, 1'b0);

    // ramp into bank 0, then stream it while frame B lands in bank 1
    write_frame(0);
    pulse_frame_done();
    lb_rows = 0;
    lb_en   = 1'b1;
    fork
      stream(0, 1'b0, 1'b1);
      begin
        repeat (20) @(posedge clk);
        write_frame(1);
        pulse_frame_done();
      end
    join
    lb_en = 1'b0;
    check_val("lb_rows", lb_rows, 32);
    stream(1, 1'b0, 1'b0);

    // bank 0 still holds the ramp: swap back, then start+frame_done together
    pulse_frame_done();
    @(negedge clk);
    check_val("avail_swap", int'(bus.frame_avail_out), 1);
    stream(0, 1'b1, 1'b1);
    stream(1, 1'b0, 1'b0);

    // start+frame_done with nothing available: swap only
    @(posedge clk); #1; bus.start_in = 1'b1; bus.wr_frame_done_in = 1'b1;
    @(posedge clk); #1; bus.start_in = 1'b0; bus.wr_frame_done_in = 1'b0;
    expect_idle("collide0", 4, 1'b1);

    // reset at row 10
    @(posedge clk); #1; bus.start_in = 1'b1;
    @(posedge clk); #1; bus.start_in = 1'b0;
    repeat (3 + 10 * PERIOD) @(negedge clk);
    check_val("mid_valid", int'(bus.data_valid_out), 1);
    check_val("mid_pix", int'(bus.pixel_data_out), 1000);
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    check_val("arst_busy", int'(bus.busy_out), 0);
    check_val("arst_valid", int'(bus.data_valid_out), 0);
    check_val("arst_pix", int'(bus.pixel_data_out), 0);
    check_val("arst_h", int'(bus.hcount_out), 0);
    check_val("arst_v", int'(bus.vcount_out), 0);
    check_val("arst_avail", int'(bus.frame_avail_out), 0);
    check_val("arst_done", int'(bus.done_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("arst_hold_done", int'(bus.done_out), 0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_avail", int'(bus.frame_avail_out), 0);
    @(posedge clk); #1; bus.start_in = 1'b1;
    @(posedge clk); #1; bus.start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_done", int'(bus.done_out), 0);
    end
    expect_idle("post_rst", 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
